// File: rtl/mapper_ram_responder_pkg.sv
// rtl/mapper_ram_responder_pkg.sv - shared state encoding and constants for the mapper RAM responder
package mapper_ram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // Wide enough for any mapper address width; users slice the low ADDR_W bits.
  localparam logic [63:0] ADDR_IDLE  = '1;
  localparam logic [7:0]  DOUT_FLOAT = 8'hFF;

endpackage

// File: rtl/mapper_ram_cache.sv
// rtl/mapper_ram_cache.sv - one-entry read cache (tag/data/valid), used under MAPPER_RAM_READ_CACHE_EN
module mapper_ram_cache #(
  parameter int ADDR_W = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [7:0]        data,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [7:0]        fill_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data
);

  logic [ADDR_W-1:0] tag;
  logic [7:0]        dat;
  logic              valid;

  assign hit  = valid && (tag == lookup_addr);
  assign data = dat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag   <= '0;
      dat   <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (fill_en) begin
      tag   <= fill_addr;
      dat   <= fill_data;
      valid <= 1'b1;
    end else if (wr_en && valid && (wr_addr == tag)) begin
      // Keep cached data coherent with writes that hit the tagged line.
      dat <= wr_data;
    end
  end

endmodule

// File: rtl/mapper_ram_responder.sv
// rtl/mapper_ram_responder.sv - mapper request to strobed memory access responder; optional MAPPER_RAM_READ_CACHE_EN
module mapper_ram_responder
  import mapper_ram_responder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 27
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_cs,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rnw,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ready,
  output logic              timeout_err
);

  localparam int              CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nxt;
  logic          ram_cs_q;
  logic          rnw_q;
  logic [CW-1:0] cnt;
  logic          start;
  logic          accept;
  logic          hit;
  logic [7:0]    cache_data;

  assign start  = ram_cs & ~ram_cs_q;
  // The idle sentinel address never reaches memory.
  assign accept = start && (state == ST_IDLE) && (addr != ADDR_IDLE[ADDR_W-1:0]);

`ifdef MAPPER_RAM_READ_CACHE_EN
  logic lookup_hit;

  mapper_ram_cache #(.ADDR_W(ADDR_W)) u_cache (
    .clk         (clk),
    .reset       (reset),
    .clear       (1'b0),
    .lookup_addr (addr),
    .hit         (lookup_hit),
    .data        (cache_data),
    .fill_en     ((state == ST_WAIT) && mem_ready && rnw_q),
    .fill_addr   (mem_addr),
    .fill_data   (mem_dout),
    .wr_en       (accept && !rnw),
    .wr_addr     (addr),
    .wr_data     (din)
  );

  assign hit = accept && rnw && lookup_hit;
`else
  assign hit        = 1'b0;
  assign cache_data = DOUT_FLOAT;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_wait  = 1'b0;
    case (state)
      ST_IDLE: begin
        cpu_wait = start;
        if (hit)         state_nxt = ST_DONE;
        else if (accept) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        cpu_wait  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        cpu_wait = 1'b1;
        if (mem_ready || (cnt == CNT_LAST)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!ram_cs) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_cs_q    <= 1'b0;
      rnw_q       <= 1'b0;
      cnt         <= '0;
      dout        <= DOUT_FLOAT;
      mem_addr    <= ADDR_IDLE[ADDR_W-1:0];
      mem_din     <= '0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ram_cs_q <= ram_cs;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mem_addr <= addr;
            mem_din  <= din;
            rnw_q    <= rnw;
            if (hit) begin
              dout <= cache_data;
            end else begin
              // Strobe is registered so it lines up with the ISSUE cycle.
              mem_rd <= rnw;
              mem_wr <= ~rnw;
            end
          end
        end
        ST_ISSUE: cnt <= '0;
        ST_WAIT: begin
          if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
          if (mem_ready) begin
            if (rnw_q) dout <= mem_dout;
          end else if (cnt == CNT_LAST) begin
            if (rnw_q) dout <= DOUT_FLOAT;
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mapper_ram_responder.sv
// tb/tb_mapper_ram_responder.sv - randomized self-checking bench with transaction-level reference model
module tb_mapper_ram_responder;

  localparam int T  = 8;
  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_cs;
  logic [AW-1:0] addr;
  logic          rnw;
  logic [7:0]    din;
  logic [7:0]    dout;
  logic          cpu_wait;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_rd;
  logic          mem_wr;
  logic [7:0]    mem_dout;
  logic          mem_ready;
  logic          timeout_err;

  mapper_ram_responder #(.TIMEOUT_CYCLES(T), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .ram_cs(ram_cs), .addr(addr), .rnw(rnw), .din(din),
    .dout(dout), .cpu_wait(cpu_wait), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  logic          exp_wait, exp_rd, exp_wr, exp_err;
  logic [AW-1:0] exp_addr;
  logic [7:0]    exp_din, exp_dout;

  // Architectural state the model tracks between transactions.
  logic [AW-1:0] m_addr;
  logic [7:0]    m_din, m_dout;
  logic          m_err;
  logic          c_valid;
  logic [AW-1:0] c_tag;
  logic [7:0]    c_data;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_wait", 32'(cpu_wait), 32'(exp_wait));
      check("mem_rd", 32'(mem_rd), 32'(exp_rd));
      check("mem_wr", 32'(mem_wr), 32'(exp_wr));
      check("mem_addr", 32'(mem_addr), 32'(exp_addr));
      check("mem_din", 32'(mem_din), 32'(exp_din));
      check("dout", 32'(dout), 32'(exp_dout));
      check("timeout_err", 32'(timeout_err), 32'(exp_err));
    end
  end

  always @(negedge clk) begin
    if (mem_rd) rd_cnt++;
    if (mem_wr) wr_cnt++;
  end

  task automatic set_reset_model();
    m_addr = '1; m_din = '0; m_dout = 8'hFF; m_err = 1'b0; c_valid = 1'b0;
    exp_wait = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_err = 1'b0;
    exp_addr = '1; exp_din = '0; exp_dout = 8'hFF;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ram_cs = 1'b0; mem_ready = 1'b0;
      addr = AW'($urandom); rnw = 1'($urandom); din = 8'($urandom); mem_dout = 8'($urandom);
    end
  endtask

  // rdy: index of the WAIT cycle carrying mem_ready (-1 = never); hold: cycles ram_cs stays high.
  task automatic txn(input logic [AW-1:0] a, input logic r, input logic [7:0] d,
                     input int rdy, input int hold, input bit noise, input logic [7:0] rdata);
    int done_c, last_c;
    bit hitc, ok;
    logic [7:0] new_dout;
    logic new_err;
    hitc = 1'b0;
`ifdef MAPPER_RAM_READ_CACHE_EN
    hitc = r && c_valid && (c_tag == a);
`endif
    ok = 1'b0;
    if (hitc) begin
      done_c = 1; new_dout = c_data; new_err = m_err;
    end else if (rdy >= 0 && rdy < T) begin
      done_c = 3 + rdy; new_dout = r ? rdata : m_dout; new_err = m_err; ok = 1'b1;
    end else begin
      done_c = 2 + T; new_dout = r ? 8'hFF : m_dout; new_err = 1'b1;
    end
    last_c = (done_c > hold) ? done_c : hold;
    for (int c = 0; c <= last_c; c++) begin
      @(posedge clk); #1;
      ram_cs    = (c < hold);
      addr      = (c == 0) ? a : AW'($urandom);
      rnw       = (c == 0) ? r : 1'($urandom);
      din       = (c == 0) ? d : 8'($urandom);
      mem_ready = (rdy >= 0 && c == 2 + rdy) || (noise && c == 1);
      mem_dout  = (rdy >= 0 && c == 2 + rdy) ? rdata : 8'($urandom);
      exp_wait  = (c < done_c);
      exp_rd    = (c == 1) && r && !hitc;
      exp_wr    = (c == 1) && !r;
      exp_addr  = (c >= 1) ? a : m_addr;
      exp_din   = (c >= 1) ? d : m_din;
      exp_dout  = (c >= done_c) ? new_dout : m_dout;
      exp_err   = (c >= done_c) ? new_err : m_err;
    end
    m_addr = a; m_din = d; m_dout = new_dout; m_err = new_err;
    if (r && ok) begin
      c_valid = 1'b1; c_tag = a; c_data = rdata;
    end else if (!r && c_valid && c_tag == a) begin
      c_data = d;
    end
  endtask

  task automatic reset_mid();
    logic [AW-1:0] a;
    logic [7:0] d;
    a = 27'h0000555;
    d = 8'($urandom);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      ram_cs = 1'b1; mem_ready = 1'b0;
      addr = (c == 0) ? a : AW'($urandom);
      rnw = 1'b1;
      din = (c == 0) ? d : 8'($urandom);
      exp_wait = 1'b1;
      exp_rd   = (c == 1);
      exp_wr   = 1'b0;
      exp_addr = (c >= 1) ? a : m_addr;
      exp_din  = (c >= 1) ? d : m_din;
    end
    @(posedge clk); #1;
    reset = 1'b1; ram_cs = 1'b0;
    set_reset_model();
    #1;
    check("rst_mid_wait", 32'(cpu_wait), 32'd0);
    check("rst_mid_addr", 32'(mem_addr), 32'h07FF_FFFF);
    @(posedge clk); #1;
    reset = 1'b0; mem_ready = 1'b1; mem_dout = 8'h77;
    idle(3);
    check("rst_late_dout", 32'(dout), 32'hFF);
  endtask

  initial begin
    int rd0, wr0;
    reset = 1'b1; ram_cs = 1'b0; addr = '0; rnw = 1'b0; din = '0;
    mem_dout = '0; mem_ready = 1'b0;
    c_tag = '0; c_data = '0;
    set_reset_model();
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Minimum-latency read.
    rd0 = rd_cnt;
    txn(27'h0004123, 1'b1, 8'h00, 0, 3, 1'b0, 8'h5A);
    check("rd_dout", 32'(dout), 32'h5A);
    check("rd_pulses", 32'(rd_cnt - rd0), 32'd1);

    // Write with ram_cs held for 10 cycles: single strobe.
    wr0 = wr_cnt;
    txn(27'h0000010, 1'b0, 8'hC3, 1, 10, 1'b0, 8'h00);
    check("wr_pulses", 32'(wr_cnt - wr0), 32'd1);
    check("wr_din", 32'(mem_din), 32'hC3);
    idle(1);

    // mem_ready on the timeout cycle wins.
    txn(27'h0000040, 1'b1, 8'h00, T - 1, 2, 1'b1, 8'h3C);
    check("edge_dout", 32'(dout), 32'h3C);
    check("edge_err", 32'(timeout_err), 32'd0);

    // Timeout, then a sticky error through a good access.
    txn(27'h0000300, 1'b1, 8'h00, -1, 4, 1'b0, 8'h00);
    check("tmo_dout", 32'(dout), 32'hFF);
    check("tmo_err", 32'(timeout_err), 32'd1);
    txn(27'h0000301, 1'b1, 8'h00, 2, 3, 1'b0, 8'hA7);
    check("sticky_err", 32'(timeout_err), 32'd1);
    check("after_tmo_dout", 32'(dout), 32'hA7);

    reset_mid();
    check("rst_err", 32'(timeout_err), 32'd0);
    txn(27'h0000777, 1'b1, 8'h00, 1, 2, 1'b0, 8'h99);
    check("post_rst_dout", 32'(dout), 32'h99);

    // Read, write same address, read again.
    rd0 = rd_cnt;
    txn(27'h0000200, 1'b1, 8'h00, 0, 2, 1'b0, 8'h11);
    txn(27'h0000200, 1'b0, 8'h22, 0, 2, 1'b0, 8'h00);
    txn(27'h0000200, 1'b1, 8'h00, 1, 2, 1'b0, 8'h22);
    check("cache_dout", 32'(dout), 32'h22);
`ifdef MAPPER_RAM_READ_CACHE_EN
    check("cache_rd_pulses", 32'(rd_cnt - rd0), 32'd1);
`else
    check("cache_rd_pulses", 32'(rd_cnt - rd0), 32'd2);
`endif

    for (int i = 0; i < 200; i++) begin
      txn(27'h0000200 + AW'($urandom_range(0, 3)), 1'($urandom), 8'($urandom),
          int'($urandom_range(0, T + 1)) - 1, int'($urandom_range(1, 12)),
          1'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(2);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
